tt_sweep_checker: RTL and testbench
===================================

Name: tt_sweep_checker

Overview:
- Sequential stimulus-and-capture stage that wraps a 4-input combinational function block (inputs A, B, C, D; output f).
- Drives all 16 ABCD input combinations in ascending order, holding each for a programmable dwell time.
- Samples f for each combination, builds the 16-bit truth table and compares it against a golden mask.
- Replaces hand-written exhaustive benches and makes the check usable on hardware.

Parameters:
- DWELL, default 2: clock cycles each vector is held. Legal range is 1 to 255.
- EXPECTED, default 16'h0000: golden truth table. Bit i holds the expected f for {A,B,C,D}=i, with A as the MSB.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request a sweep; acted on only in IDLE.
- f  in  1  output of the function under test.
- A  out  1  stimulus bit 3 (MSB).
- B  out  1  stimulus bit 2.
- C  out  1  stimulus bit 1.
- D  out  1  stimulus bit 0.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at the end of a sweep.
- table_out  out  16  captured truth table; bit i = f sampled at vector i.
- mismatch_cnt  out  5  number of vectors where f differs from EXPECTED (0 to 16).
- pass  out  1  high when the last completed sweep had mismatch_cnt==0.

Behaviour:
- Reset: when rst_n==0 at a clk edge, state=IDLE and idx, dwell_cnt, A to D, busy, done, table_out, mismatch_cnt and pass all go to 0. Reset has priority over all other events and aborts a sweep mid-run with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - A to D = 0; busy = 0.
  - start==1 at an edge: clear table_out, mismatch_cnt and pass; set idx=0 and dwell_cnt=0; go to RUN.
- RUN:
  - {A,B,C,D} = idx, driven from registers. busy = 1. start is ignored.
  - Each cycle: if dwell_cnt < DWELL-1, increment dwell_cnt.
  - When dwell_cnt == DWELL-1, on that edge:
    - table_out[idx] <= f.
    - If f != EXPECTED[idx], mismatch_cnt increments.
    - If idx==15, go to DONE; otherwise idx increments and dwell_cnt = 0.
  - f is sampled at the last cycle of the dwell. This means f sees the new vector for DWELL cycles; with DWELL=1 the sample is taken in the same cycle the vector is driven, which is legal for a combinational DUT.
  - A sweep therefore spends exactly 16*DWELL cycles in RUN.
- DONE:
  - Lasts one cycle. done = 1, busy = 0, A to D = 0.
  - pass <= (mismatch_cnt == 0), including the final-vector update.
  - Next state is IDLE; start is ignored in this cycle.
- Holding: table_out, mismatch_cnt and pass hold their values until the next accepted start or reset.
- Held start: start held high continuously gives back-to-back sweeps, each separated by the DONE cycle plus one IDLE cycle.
- Overflow: mismatch_cnt cannot overflow; its maximum is 16.

Optional Feature:
- Macro: TT_SWEEP_FIRST_FAIL_EN.
- When defined, adds two outputs:
  - first_fail_idx (out, 4): index of the lowest-numbered mismatching vector.
  - first_fail_valid (out, 1): high once any mismatch has been recorded in the current sweep.
- Both outputs clear on reset and on an accepted start, are captured on the first mismatch only, and hold afterwards.
- When the macro is undefined, neither port nor the associated logic exists.

Decomposition:
- Shared package tt_pkg holds:
  - state enum: IDLE, RUN, DONE;
  - NUM_VECTORS=16, IDX_W=4, CNT_W=5;
  - a DWELL_W constant (8).
- One natural sub-module, tt_vec_counter, owns idx and dwell_cnt. It provides two strobes:
  - sample_stb, asserted when dwell_cnt==DWELL-1;
  - last_stb, asserted when sample_stb is high and idx==15.
- Compare, accumulate and FSM logic stay in the top module.

Test Plan:
1. DUT model f=(A&B)|(C&~D), EXPECTED=16'hF444, DWELL=2, one start pulse. Required: busy for exactly 32 cycles, then done pulse, table_out=16'hF444, mismatch_cnt=0, pass=1. With the macro, first_fail_valid=0.
2. Same parameters with f stuck at 0. Required: table_out=16'h0000, mismatch_cnt=7, pass=0. With the macro, first_fail_idx=2 and first_fail_valid=1.
3. f = ~((A&B)|(C&~D)), EXPECTED=16'hF444. Required: table_out=16'h0BBB, mismatch_cnt=16, pass=0.
4. DWELL=1, monitor {A,B,C,D} each cycle in RUN. Required: values 0,1,...,15 on consecutive cycles, done asserted on the cycle after vector 15, table_out correct.
5. start held high for 3 sweeps with the test-1 model. Required: exactly 3 done pulses; stats cleared at each accepted start; start pulses during RUN cause no restart.
6. rst_n=0 while idx==7. Required: next edge gives busy=0, A to D=0, table_out=0, mismatch_cnt=0, and no done pulse; a following start runs a full clean sweep.

Source files
------------

// File: rtl/tt_pkg.sv
// tt_pkg: shared state type and sizing constants for the truth-table sweep checker
package tt_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NUM_VECTORS = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;
  localparam int DWELL_W = 8;
endpackage

// File: rtl/tt_vec_counter.sv
// tt_vec_counter: steps the vector index and the per-vector dwell counter, flags the sample cycle
module tt_vec_counter
  import tt_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             sample_stb,
  output logic             last_stb
);
  logic [DWELL_W-1:0] dwell_cnt;
  assign sample_stb = en && dwell_cnt == DWELL_W'(DWELL - 1);
  assign last_stb = sample_stb && idx == IDX_W'(NUM_VECTORS - 1);
  always_ff @(posedge clk)
    if (!rst_n || clr) begin
      idx <= '0;
      dwell_cnt <= '0;
    end else if (sample_stb) begin
      dwell_cnt <= '0;
      if (!last_stb) idx <= idx + IDX_W'(1);
    end else if (en) dwell_cnt <= dwell_cnt + DWELL_W'(1);
endmodule

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: sweeps all 16 ABCD vectors, captures f into a truth table and scores it against EXPECTED
// Optional TT_SWEEP_FIRST_FAIL_EN adds first_fail_idx/first_fail_valid.
module tt_sweep_checker
  import tt_pkg::*;
#(
  parameter int                     DWELL    = 2,
  parameter logic [NUM_VECTORS-1:0] EXPECTED = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   f,
  output logic                   A,
  output logic                   B,
  output logic                   C,
  output logic                   D,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_VECTORS-1:0] table_out,
  output logic [CNT_W-1:0]       mismatch_cnt,
  output logic                   pass
`ifdef TT_SWEEP_FIRST_FAIL_EN
  ,
  output logic [IDX_W-1:0]       first_fail_idx,
  output logic                   first_fail_valid
`endif
);
  state_t state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic sample_stb, last_stb, accept, miss;
  assign accept = state == IDLE && start;
  assign miss = sample_stb && f != EXPECTED[idx];
  tt_vec_counter #(.DWELL(DWELL)) u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .clr(accept),
    .en(state == RUN),
    .idx(idx),
    .sample_stb(sample_stb),
    .last_stb(last_stb)
  );
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last_stb ? DONE : RUN) : IDLE;
    busy = state == RUN;
    done = state == DONE;
    {A, B, C, D} = busy ? idx : '0;
  end
  // pass is taken in DONE so it already includes the final vector's score
  always_ff @(posedge clk)
    if (!rst_n || accept) begin
      table_out <= '0;
      mismatch_cnt <= '0;
      pass <= 1'b0;
    end else begin
      if (sample_stb) table_out[idx] <= f;
      if (miss) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
      if (state == DONE) pass <= mismatch_cnt == '0;
    end
`ifdef TT_SWEEP_FIRST_FAIL_EN
  always_ff @(posedge clk)
    if (!rst_n || accept) begin
      first_fail_idx <= '0;
      first_fail_valid <= 1'b0;
    end else if (miss && !first_fail_valid) begin
      first_fail_idx <= idx;
      first_fail_valid <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb_tt_sweep_checker: randomized self-checking bench for tt_sweep_checker (DWELL=2 and DWELL=1 instances)
module tb_tt_sweep_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, start, start1, f, f1;
  logic A, B, C, D, busy, done, pass;
  logic A1, B1, C1, D1, busy1, done1, pass1;
  logic [15:0] table_out, table1, rtab;
  logic [4:0] mc, mc1;
  logic [1:0] mode;
  int checks = 0, errors = 0;
`ifdef TT_SWEEP_FIRST_FAIL_EN
  logic [3:0] ffi, ffi1;
  logic ffv, ffv1;
`endif
  // mode 0: (A&B)|(C&~D), 1: stuck-at-0, 2: inverted, 3: random truth table rtab
  always_comb begin
    f = mode == 2'd0 ? ((A & B) | (C & ~D)) : mode == 2'd1 ? 1'b0 :
        mode == 2'd2 ? ~((A & B) | (C & ~D)) : rtab[{A, B, C, D}];
    f1 = mode == 2'd0 ? ((A1 & B1) | (C1 & ~D1)) : mode == 2'd1 ? 1'b0 :
         mode == 2'd2 ? ~((A1 & B1) | (C1 & ~D1)) : rtab[{A1, B1, C1, D1}];
  end
  tt_sweep_checker #(.DWELL(2), .EXPECTED(16'hF444)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f(f),
    .A(A), .B(B), .C(C), .D(D), .busy(busy), .done(done),
    .table_out(table_out), .mismatch_cnt(mc), .pass(pass)
`ifdef TT_SWEEP_FIRST_FAIL_EN
    , .first_fail_idx(ffi), .first_fail_valid(ffv)
`endif
  );
  tt_sweep_checker #(.DWELL(1), .EXPECTED(16'hF444)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .f(f1),
    .A(A1), .B(B1), .C(C1), .D(D1), .busy(busy1), .done(done1),
    .table_out(table1), .mismatch_cnt(mc1), .pass(pass1)
`ifdef TT_SWEEP_FIRST_FAIL_EN
    , .first_fail_idx(ffi1), .first_fail_valid(ffv1)
`endif
  );
  function automatic int lowest_bit(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction
  // one start pulse on dut, bounded wait for done, then one more cycle so pass is settled
  task automatic do_sweep(input bit noisy, output int bc, output int dc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    dc = 0;
    for (int t = 0; t < 200; t++) begin
      start = (noisy && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (busy) bc++;
      if (done) begin
        dc++;
        start = 1'b0;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    start1 = 1'b0;
    mode = 2'd0;
    rtab = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if ({A, B, C, D} !== 4'h0) begin errors++; $display("FAIL reset_abcd got %h want 0", {A, B, C, D}); end
    checks++; if (table_out !== 16'h0) begin errors++; $display("FAIL reset_table got %h want 0", table_out); end
    checks++; if (mc !== 5'd0) begin errors++; $display("FAIL reset_mc got %0d want 0", mc); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b want 0", busy1); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_basic();
    int bc, dc;
    mode = 2'd0;
    do_sweep(1'b0, bc, dc);
    checks++; if (bc !== 32) begin errors++; $display("FAIL basic_busy_cycles got %0d want 32", bc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL basic_done got %0d want 1", dc); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    checks++; if (table_out !== 16'hF444) begin errors++; $display("FAIL basic_table got %h want f444", table_out); end
    checks++; if (mc !== 5'd0) begin errors++; $display("FAIL basic_mc got %0d want 0", mc); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL basic_pass got %b want 1", pass); end
`ifdef TT_SWEEP_FIRST_FAIL_EN
    checks++; if (ffv !== 1'b0) begin errors++; $display("FAIL basic_ffv got %b want 0", ffv); end
`endif
  endtask
  task automatic test_stuck();
    int bc, dc;
    mode = 2'd1;
    do_sweep(1'b0, bc, dc);
    checks++; if (dc !== 1) begin errors++; $display("FAIL stuck_done got %0d want 1", dc); end
    checks++; if (table_out !== 16'h0000) begin errors++; $display("FAIL stuck_table got %h want 0000", table_out); end
    checks++; if (mc !== 5'd7) begin errors++; $display("FAIL stuck_mc got %0d want 7", mc); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL stuck_pass got %b want 0", pass); end
`ifdef TT_SWEEP_FIRST_FAIL_EN
    checks++; if (ffv !== 1'b1 || ffi !== 4'd2) begin errors++; $display("FAIL stuck_first got %b/%0d want 1/2", ffv, ffi); end
`endif
  endtask
  task automatic test_inverted();
    int bc, dc;
    mode = 2'd2;
    do_sweep(1'b0, bc, dc);
    checks++; if (table_out !== 16'h0BBB) begin errors++; $display("FAIL inv_table got %h want 0bbb", table_out); end
    checks++; if (mc !== 5'd16) begin errors++; $display("FAIL inv_mc got %0d want 16", mc); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL inv_pass got %b want 0", pass); end
`ifdef TT_SWEEP_FIRST_FAIL_EN
    checks++; if (ffv !== 1'b1 || ffi !== 4'd0) begin errors++; $display("FAIL inv_first got %b/%0d want 1/0", ffv, ffi); end
`endif
  endtask
  // random truth tables with start toggled randomly during RUN (must be ignored)
  task automatic test_random();
    int bc, dc, mm;
    for (int n = 0; n < 4; n++) begin
      rtab = 16'($urandom);
      if (n == 0) rtab = 16'hF444 ^ 16'h8000;
      mode = 2'd3;
      mm = $countones(rtab ^ 16'hF444);
      do_sweep(1'b1, bc, dc);
      checks++; if (bc !== 32 || dc !== 1) begin errors++; $display("FAIL rand_timing got %0d/%0d want 32/1", bc, dc); end
      checks++; if (table_out !== rtab) begin errors++; $display("FAIL rand_table got %h want %h", table_out, rtab); end
      checks++; if (mc !== 5'(mm)) begin errors++; $display("FAIL rand_mc got %0d want %0d", mc, mm); end
      checks++; if (pass !== (mm == 0)) begin errors++; $display("FAIL rand_pass got %b want %b", pass, mm == 0); end
`ifdef TT_SWEEP_FIRST_FAIL_EN
      checks++; if (ffv !== (mm != 0) || (mm != 0 && ffi !== 4'(lowest_bit(rtab ^ 16'hF444)))) begin
        errors++; $display("FAIL rand_first got %b/%0d want %b/%0d", ffv, ffi, mm != 0, lowest_bit(rtab ^ 16'hF444));
      end
`endif
    end
  endtask
  task automatic test_dwell1();
    int k, mm;
    mode = 2'd3;
    rtab = 16'($urandom);
    mm = $countones(rtab ^ 16'hF444);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    k = 0;
    while (busy1 && k < 20) begin
      checks++; if ({A1, B1, C1, D1} !== 4'(k)) begin errors++; $display("FAIL d1_vec got %0d want %0d", {A1, B1, C1, D1}, k); end
      k++;
      @(negedge clk);
    end
    checks++; if (k !== 16) begin errors++; $display("FAIL d1_run_cycles got %0d want 16", k); end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL d1_done got %b want 1", done1); end
    @(negedge clk);
    checks++; if (table1 !== rtab) begin errors++; $display("FAIL d1_table got %h want %h", table1, rtab); end
    checks++; if (mc1 !== 5'(mm) || pass1 !== (mm == 0)) begin errors++; $display("FAIL d1_score got %0d/%b want %0d/%b", mc1, pass1, mm, mm == 0); end
  endtask
  task automatic test_back_to_back();
    int dn, bc;
    logic prev;
    mode = 2'd0;
    start = 1'b1;
    dn = 0;
    bc = 0;
    prev = 1'b0;
    for (int t = 0; t < 400 && dn < 3; t++) begin
      @(negedge clk);
      if (busy && !prev) begin
        checks++; if (table_out !== 16'h0 || mc !== 5'd0 || pass !== 1'b0) begin
          errors++; $display("FAIL b2b_clear got %h/%0d/%b want 0/0/0", table_out, mc, pass);
        end
      end
      if (busy) bc++;
      if (done) begin
        dn++;
        if (dn == 3) start = 1'b0;
      end
      prev = busy;
    end
    start = 1'b0;
    checks++; if (dn !== 3) begin errors++; $display("FAIL b2b_done_count got %0d want 3", dn); end
    checks++; if (bc !== 96) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 96", bc); end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stopped got %b want 0", busy); end
    checks++; if (pass !== 1'b1 || table_out !== 16'hF444) begin errors++; $display("FAIL b2b_result got %b/%h want 1/f444", pass, table_out); end
  endtask
  task automatic test_reset_midrun();
    int bc, dc;
    bit found, saw_done;
    mode = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    saw_done = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      if (done) saw_done = 1'b1;
      if (busy && {A, B, C, D} == 4'd7) found = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_reach7 got 0 want 1"); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || {A, B, C, D} !== 4'h0) begin errors++; $display("FAIL mid_idle got %b/%h want 0/0", busy, {A, B, C, D}); end
    checks++; if (table_out !== 16'h0 || mc !== 5'd0) begin errors++; $display("FAIL mid_stats got %h/%0d want 0/0", table_out, mc); end
    checks++; if (done !== 1'b0 || saw_done) begin errors++; $display("FAIL mid_done got %b/%b want 0/0", done, saw_done); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_quiet got %b/%b want 0/0", done, busy); end
    do_sweep(1'b0, bc, dc);
    checks++; if (bc !== 32 || dc !== 1) begin errors++; $display("FAIL mid_resweep got %0d/%0d want 32/1", bc, dc); end
    checks++; if (table_out !== 16'hF444 || pass !== 1'b1) begin errors++; $display("FAIL mid_result got %h/%b want f444/1", table_out, pass); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stuck();
    test_inverted();
    test_random();
    test_dwell1();
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
